present_decrypt: RTL and testbench
==================================

PRESENT_DECRYPT -- requirements
Module: present_decrypt

Interface
REQ-001 Parameter KEY_SIZE, default 80, SHALL be the cipher key width in bits.
REQ-002 Parameter SIZE, default 64, SHALL be the block width in bits.
REQ-003 Parameter NUM_ROUNDS, default 32, SHALL be the number of round keys; there are NUM_ROUNDS-1 full rounds.
REQ-004 clk  input  1  SHALL be the single clock; every register updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-006 start  input  1  SHALL request decryption; it is sampled only in IDLE.
REQ-007 orig_key  input  KEY_SIZE  SHALL be the PRESENT-80 cipher key; it is captured when start is accepted.
REQ-008 ciphertext  input  SIZE  SHALL be the block to decrypt; it is captured when start is accepted.
REQ-009 plaintext  output  SIZE  SHALL be the registered result, held stable until the next accepted start.
REQ-010 busy  output  1  SHALL be high in every state except IDLE.
REQ-011 done  output  1  SHALL be a one-cycle pulse marking plaintext valid.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, KEYEXP, ROUND and FINAL.
REQ-013 IDLE with start=1 SHALL load state<=ciphertext, keyreg<=orig_key and rc<=1, then go to KEYEXP.
REQ-014 Each KEYEXP cycle SHALL apply the forward key update: rotate keyreg left 61; S-box on [79:76]; keyreg[19:15]^=rc; rc++.
REQ-015 After 31 KEYEXP cycles keyreg SHALL equal K32, rc SHALL equal 31, and the FSM SHALL go to ROUND.
REQ-016 Each ROUND cycle SHALL compute state<=invS(invP(state^keyreg[79:16])) and apply the inverse key update: keyreg[19:15]^=rc; inverse S-box on [79:76]; rotate right 61; rc--.
REQ-017 After 31 ROUND cycles (rc decrements 31 down to 1) the FSM SHALL go to FINAL.
REQ-018 FINAL SHALL register plaintext<=state^keyreg[79:16] (K1), pulse done for one cycle and return to IDLE.
REQ-019 Latency SHALL be 64 cycles: done is high in the 64th cycle after the cycle in which start was sampled high.
REQ-020 start while busy SHALL be ignored, with no effect on the operation in progress.
REQ-021 start in the cycle done is high SHALL be accepted, because the FSM is already back in IDLE.
REQ-022 Changes to orig_key or ciphertext after acceptance SHALL have no effect on the running operation.
REQ-023 invP SHALL be the inverse of P(i)=16*i mod 63 for i<63, with bit 63 fixed; invS SHALL be the inverse of S = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force IDLE and clear plaintext, busy, done, state, keyreg and rc to 0, including mid-operation.
REQ-025 An operation aborted by reset SHALL NOT produce a done pulse.

Configuration
REQ-026 With PRESENT_KEY_CACHE_EN defined, the block SHALL store orig_key and the expanded K32 register at the end of each KEYEXP.
REQ-027 With the cache enabled, an accepted start whose orig_key equals the cached key with the cache valid SHALL load K32 directly, set rc=31 and skip KEYEXP, giving a latency of 33 cycles.
REQ-028 With the cache enabled, reset SHALL invalidate the cache.
REQ-029 Without PRESENT_KEY_CACHE_EN, no cache storage SHALL exist and latency SHALL always be 64 cycles.

Structure
REQ-030 The shared package present_pkg SHALL hold the S-box and inverse S-box tables, the pLayer/invP functions, the forward and inverse key-update functions, and the state enum type.
REQ-031 The encryptor SHALL reuse the same present_pkg.
REQ-032 The datapath SHALL be one sub-module, present_inv_round: combinational key xor followed by invP and invS.

Verification
REQ-033 key=0, ct=0x5579C1387B228445, start -> plaintext=0x0000000000000000, done high 64 cycles after start.
REQ-034 key=FFFF_FFFFFFFF_FFFFFFFF, ct=0xE72C46C0F5945049 -> plaintext=0x0000000000000000.
REQ-035 key=0, ct=0xA112FFC72F68417B -> plaintext=0xFFFFFFFFFFFFFFFF; then key=all ones, ct=0x3333DCD3213210D2 started in the done cycle -> plaintext=0xFFFFFFFFFFFFFFFF.
REQ-036 start pulsed at cycle 10 of an operation -> ignored, single done at cycle 64, correct result.
REQ-037 rst_n=0 at cycle 40 -> busy=0, done=0 and plaintext=0 next cycle; no done pulse follows.
REQ-038 With PRESENT_KEY_CACHE_EN: the REQ-033 vector run twice -> second done at 33 cycles with the same plaintext; a different key -> 64 cycles.

Source files
------------

// File: rtl/present_pkg.sv
// PRESENT cipher shared definitions: S-box tables, bit permutation
// and key-schedule steps used by both encrypt and decrypt datapaths.
package present_pkg;

   localparam int KEY_W = 80;
   localparam int BLK_W = 64;

   // nibble i of the table is S(i)
   localparam logic [63:0] SBOX_TBL     = 64'h2174_8FE3_DA09_B65C;
   localparam logic [63:0] INV_SBOX_TBL = 64'hA970_364B_D21C_8FE5;

   typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, FINAL} state_t;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      return SBOX_TBL[{x, 2'b00} +: 4];
   endfunction

   function automatic logic [3:0] inv_sbox(input logic [3:0] x);
      return INV_SBOX_TBL[{x, 2'b00} +: 4];
   endfunction

   function automatic logic [BLK_W-1:0] sbox_layer(input logic [BLK_W-1:0] x);
      logic [BLK_W-1:0] y;
      for (int i = 0; i < 16; i++) y[i*4 +: 4] = sbox(x[i*4 +: 4]);
      return y;
   endfunction

   function automatic logic [BLK_W-1:0] inv_sbox_layer(input logic [BLK_W-1:0] x);
      logic [BLK_W-1:0] y;
      for (int i = 0; i < 16; i++) y[i*4 +: 4] = inv_sbox(x[i*4 +: 4]);
      return y;
   endfunction

   // bit i moves to 16*i mod 63, bit 63 stays put
   function automatic logic [BLK_W-1:0] p_layer(input logic [BLK_W-1:0] x);
      logic [BLK_W-1:0] y;
      logic [5:0] src;
      logic [5:0] dst;
      y[63] = x[63];
      for (int i = 0; i < 63; i++) begin
         src    = 6'(i);
         dst    = 6'((16 * i) % 63);
         y[dst] = x[src];
      end
      return y;
   endfunction

   function automatic logic [BLK_W-1:0] inv_p_layer(input logic [BLK_W-1:0] x);
      logic [BLK_W-1:0] y;
      logic [5:0] src;
      logic [5:0] dst;
      y[63] = x[63];
      for (int i = 0; i < 63; i++) begin
         dst    = 6'(i);
         src    = 6'((16 * i) % 63);
         y[dst] = x[src];
      end
      return y;
   endfunction

   function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k,
                                                input logic [4:0] rc);
      logic [KEY_W-1:0] t;
      t          = {k[18:0], k[79:19]};
      t[79:76]   = sbox(t[79:76]);
      t[19:15]   = t[19:15] ^ rc;
      return t;
   endfunction

   function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k,
                                                input logic [4:0] rc);
      logic [KEY_W-1:0] t;
      t          = k;
      t[19:15]   = t[19:15] ^ rc;
      t[79:76]   = inv_sbox(t[79:76]);
      return {t[60:0], t[79:61]};
   endfunction

endpackage

// File: rtl/present_inv_round.sv
// One PRESENT decryption round: round-key xor, inverse permutation,
// inverse S-box layer. Purely combinational.
module present_inv_round
   import present_pkg::*;
(
   input  logic [BLK_W-1:0] state,
   input  logic [BLK_W-1:0] round_key,
   output logic [BLK_W-1:0] next_state
);

   always_comb next_state = inv_sbox_layer(inv_p_layer(state ^ round_key));

endmodule

// File: rtl/present_decrypt.sv
// Iterative PRESENT-80 decryptor: forward key expansion, 31 inverse rounds.
// Define PRESENT_KEY_CACHE_EN to reuse the last expanded K32 for a repeated key.
module present_decrypt
   import present_pkg::*;
#(
   parameter int KEY_SIZE   = 80,
   parameter int SIZE       = 64,
   parameter int NUM_ROUNDS = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [KEY_SIZE-1:0] orig_key,
   input  logic [SIZE-1:0]     ciphertext,
   output logic [SIZE-1:0]     plaintext,
   output logic                busy,
   output logic                done
);

   localparam logic [4:0] LAST_RC = 5'(NUM_ROUNDS - 1);

   state_t              st;
   state_t              st_nx;
   logic [SIZE-1:0]     data;
   logic [KEY_SIZE-1:0] keyreg;
   logic [4:0]          rc;
   logic [SIZE-1:0]     round_out;
   logic [KEY_SIZE-1:0] key_nx_fwd;
   logic                hit;
   logic [KEY_SIZE-1:0] load_key;
   logic [4:0]          load_rc;

   present_inv_round u_round (
      .state      (data),
      .round_key  (keyreg[KEY_SIZE-1 -: SIZE]),
      .next_state (round_out)
   );

   assign key_nx_fwd = key_fwd(keyreg, rc);

`ifdef PRESENT_KEY_CACHE_EN
   logic [KEY_SIZE-1:0] key_in;
   logic [KEY_SIZE-1:0] cache_key;
   logic [KEY_SIZE-1:0] cache_k32;
   logic                cache_vld;

   always_comb begin
      hit      = cache_vld && (orig_key == cache_key);
      load_key = hit ? cache_k32 : orig_key;
      load_rc  = hit ? LAST_RC : 5'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_in    <= '0;
         cache_key <= '0;
         cache_k32 <= '0;
         cache_vld <= 1'b0;
      end else begin
         if (st == IDLE && start) key_in <= orig_key;
         if (st == KEYEXP && rc == LAST_RC) begin
            cache_key <= key_in;
            cache_k32 <= key_nx_fwd;
            cache_vld <= 1'b1;
         end
      end
   end
`else
   always_comb begin
      hit      = 1'b0;
      load_key = orig_key;
      load_rc  = 5'd1;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) st <= IDLE;
      else        st <= st_nx;
   end

   always_comb begin
      st_nx = st;
      busy  = (st != IDLE);
      unique case (st)
         IDLE:   if (start) st_nx = hit ? ROUND : KEYEXP;
         KEYEXP: if (rc == LAST_RC) st_nx = ROUND;
         ROUND:  if (rc == 5'd1) st_nx = FINAL;
         FINAL:  st_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data      <= '0;
         keyreg    <= '0;
         rc        <= '0;
         plaintext <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (st)
            IDLE: if (start) begin
               data   <= ciphertext;
               keyreg <= load_key;
               rc     <= load_rc;
            end
            // rc parks at the last value so ROUND starts undoing from K32
            KEYEXP: begin
               keyreg <= key_nx_fwd;
               if (rc != LAST_RC) rc <= rc + 5'd1;
            end
            ROUND: begin
               data   <= round_out;
               keyreg <= key_inv(keyreg, rc);
               rc     <= rc - 5'd1;
            end
            FINAL: begin
               plaintext <= data ^ keyreg[KEY_SIZE-1 -: SIZE];
               done      <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_present_decrypt.sv
// Directed bench for present_decrypt: known-answer vectors, latency,
// ignored start, back-to-back start, reset abort and key cache.
module tb_present_decrypt;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [79:0] orig_key = '0;
   logic [63:0] ciphertext = '0;
   logic [63:0] plaintext;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int lat = 0;
   int cnt0;

   logic [63:0] sb_pt[$];
   int          sb_lat[$];

   localparam logic [79:0] K0 = 80'h0;
   localparam logic [79:0] K1 = {80{1'b1}};

`ifdef PRESENT_KEY_CACHE_EN
   localparam int LAT_REPEAT = 33;
`else
   localparam int LAT_REPEAT = 64;
`endif

   present_decrypt dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .orig_key   (orig_key),
      .ciphertext (ciphertext),
      .plaintext  (plaintext),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

   task automatic check(input string tag, input logic [79:0] obs,
                        input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   // called #1 after a rising edge; start is sampled at the next edge
   task automatic launch(input logic [79:0] k, input logic [63:0] ct,
                         input bit push, input logic [63:0] exp_pt,
                         input int exp_lat);
      start      = 1'b1;
      orig_key   = k;
      ciphertext = ct;
      if (push) begin
         sb_pt.push_back(exp_pt);
         sb_lat.push_back(exp_lat);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 1;
   endtask

   task automatic wait_done(input string tag);
      logic [63:0] exp_pt;
      int          exp_lat;
      for (int n = 0; n < 100; n++) begin
         if (done === 1'b1) break;
         tick(1);
      end
      check({tag, "_done"}, 80'(done), 80'(1'b1));
      if (sb_pt.size() == 0) begin
         check({tag, "_sb_empty"}, 80'(1), 80'(0));
      end else begin
         exp_pt  = sb_pt.pop_front();
         exp_lat = sb_lat.pop_front();
         check({tag, "_pt"}, 80'(plaintext), 80'(exp_pt));
         check({tag, "_lat"}, 80'(lat), 80'(exp_lat));
      end
      check({tag, "_idle"}, 80'(busy), 80'(1'b0));
   endtask

   initial begin
      tick(3);
      check("rst_pt", 80'(plaintext), 80'(0));
      check("rst_busy", 80'(busy), 80'(0));
      check("rst_done", 80'(done), 80'(0));
      rst_n = 1'b1;
      tick(1);

      launch(K0, 64'h5579C1387B228445, 1, 64'h0, 64);
      check("t1_busy", 80'(busy), 80'(1));
      wait_done("t1");
      tick(1);
      check("t1_pulse", 80'(done), 80'(0));

      launch(K1, 64'hE72C46C0F5945049, 1, 64'h0, 64);
      wait_done("t2");
      tick(2);

      launch(K0, 64'hA112FFC72F68417B, 1, {64{1'b1}}, 64);
      wait_done("t3");
      launch(K1, 64'h3333DCD3213210D2, 1, {64{1'b1}}, 64);
      check("t4_pulse", 80'(done), 80'(0));
      check("t4_busy", 80'(busy), 80'(1));
      wait_done("t4");
      tick(2);

      cnt0 = done_cnt;
      launch(K0, 64'hA112FFC72F68417B, 1, {64{1'b1}}, 64);
      tick(9);
      start      = 1'b1;
      orig_key   = K1;
      ciphertext = 64'h0123456789ABCDEF;
      tick(1);
      start = 1'b0;
      check("t5_busy", 80'(busy), 80'(1));
      wait_done("t5");
      tick(70);
      check("t5_once", 80'(done_cnt), 80'(cnt0 + 1));

      cnt0 = done_cnt;
      launch(K0, 64'h5579C1387B228445, 0, 64'h0, 0);
      tick(38);
      rst_n = 1'b0;
      tick(1);
      check("t6_busy", 80'(busy), 80'(0));
      check("t6_done", 80'(done), 80'(0));
      check("t6_pt", 80'(plaintext), 80'(0));
      rst_n = 1'b1;
      tick(80);
      check("t6_nodone", 80'(done_cnt), 80'(cnt0));

      launch(K0, 64'h5579C1387B228445, 1, 64'h0, 64);
      wait_done("t7a");
      tick(1);
      launch(K0, 64'h5579C1387B228445, 1, 64'h0, LAT_REPEAT);
      wait_done("t7b");
      tick(1);
      launch(K1, 64'hE72C46C0F5945049, 1, 64'h0, 64);
      wait_done("t7c");
      check("sb_drained", 80'(sb_pt.size()), 80'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
